// File: rtl/native_mem_pkg.sv
// native_mem_pkg: state encoding and shared constants for the native memory responder.
`default_nettype none

package native_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LAT_W = 4;

  // All-ones pattern; counters slice off their own width as the saturation value.
  localparam logic [63:0] CNT_SAT_ONES = '1;

endpackage

`default_nettype wire

// File: rtl/native_mem_array.sv
// native_mem_array: single-port RAM with per-byte write enables and a registered read port.
`default_nettype none

module native_mem_array
  import native_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int NBYTES     = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [MEM_ADDR_W-1:0] idx,
  input  logic                  rd_en,
  input  logic [NBYTES-1:0]     wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] ram [2**MEM_ADDR_W];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (wr_be[b]) ram[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= ram[idx];
  end

endmodule

`default_nettype wire

// File: rtl/native_mem_responder.sv
// native_mem_responder: fixed-latency slave on the cache back-end native interface,
// with saturating read/write counters and a sticky protocol-violation flag.
`default_nettype none

module native_mem_responder
  import native_mem_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int NBYTES     = DATA_W / 8,
  parameter int BYTE_W     = $clog2(NBYTES),
  parameter int MEM_ADDR_W = 10,
  parameter int LAT        = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [NBYTES-1:0] mem_wstrb,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic              proto_err,
  input  logic              proto_err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_SAT_ONES[CNT_W-1:0];

  state_t            state, state_nx;
  logic [LAT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NBYTES-1:0] wstrb_q;

  logic                  accept, commit, busy, violation, rd_en;
  logic [MEM_ADDR_W-1:0] idx;
  logic [NBYTES-1:0]     wr_be;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          cnt_nx   = LAT_W'(LAT - 1);
          state_nx = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - LAT_W'(1);
        if (cnt <= LAT_W'(1)) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && mem_valid;
  assign commit = (state == RESP);
  assign busy   = (state == WAIT) || (state == RESP);

  assign violation = busy && (!mem_valid || (mem_addr != addr_q) ||
                              (mem_wdata != wdata_q) || (mem_wstrb != wstrb_q));

  // With LAT=1 the read is launched from IDLE, before the latches hold the request.
  assign idx   = (state == IDLE) ? mem_addr[BYTE_W +: MEM_ADDR_W] : addr_q[BYTE_W +: MEM_ADDR_W];
  assign rd_en = (state_nx == RESP) &&
                 (((state == IDLE) ? mem_wstrb : wstrb_q) == '0);
  assign wr_be = commit ? wstrb_q : '0;

  native_mem_array #(
    .DATA_W     (DATA_W),
    .MEM_ADDR_W (MEM_ADDR_W),
    .NBYTES     (NBYTES)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .idx     (idx),
    .rd_en   (rd_en),
    .wr_be   (wr_be),
    .wr_data (wdata_q),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_ready <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      mem_ready <= (state_nx == RESP);
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (commit) begin
        if (wstrb_q == '0) begin
          if (rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
        end else begin
          if (wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (violation)          proto_err <= 1'b1;
      else if (proto_err_clr) proto_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_native_mem_responder.sv
// tb_native_mem_responder: two responder instances (LAT=2 wide counters, LAT=1 2-bit counters
// with a 16-word aliasing RAM) driven with randomized transfers against a word-array model.
`default_nettype none
`timescale 1ns/1ps

module tb_native_mem_responder;

  localparam int AW = 12, DW = 32, NB = 4;
  localparam int LAT_A = 2, CW_A = 16, MA_A = 10;
  localparam int LAT_B = 1, CW_B = 2,  MA_B = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic va, vb, ya, yb, pa, pb, ca, cb;
  logic [AW-1:0] aa, ab;
  logic [DW-1:0] wa, wb, ra, rb;
  logic [NB-1:0] sa, sb;
  logic [CW_A-1:0] rca, wca;
  logic [CW_B-1:0] rcb, wcb;

  native_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MA_A), .LAT(LAT_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset(rst_n), .mem_valid(va), .mem_addr(aa), .mem_wdata(wa), .mem_wstrb(sa),
    .mem_rdata(ra), .mem_ready(ya), .rd_cnt(rca), .wr_cnt(wca), .proto_err(pa), .proto_err_clr(ca));

  native_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MA_B), .LAT(LAT_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(rst_n), .mem_valid(vb), .mem_addr(ab), .mem_wdata(wb), .mem_wstrb(sb),
    .mem_rdata(rb), .mem_ready(yb), .rd_cnt(rcb), .wr_cnt(wcb), .proto_err(pb), .proto_err_clr(cb));

  // Reference model: one word array per instance plus completed-transfer counts.
  logic [DW-1:0] model [2][1024];
  int rd_m [2];
  int wr_m [2];
  int ready_at;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_ready(input int d);
    return d != 0 ? yb : ya;
  endfunction
  function automatic logic [DW-1:0] get_rdata(input int d);
    return d != 0 ? rb : ra;
  endfunction
  function automatic int get_rdcnt(input int d);
    return d != 0 ? int'(rcb) : int'(rca);
  endfunction
  function automatic int get_wrcnt(input int d);
    return d != 0 ? int'(wcb) : int'(wca);
  endfunction

  task automatic drive(input int d, input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] w, input logic [NB-1:0] s);
    if (d != 0) begin vb = v; ab = a; wb = w; sb = s; end
    else        begin va = v; aa = a; wa = w; sa = s; end
  endtask

  task automatic idle(input int d, input int n);
    drive(d, 1'b0, '0, '0, '0);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issues one transfer in the current (IDLE) cycle and returns #1 into cycle LAT+1,
  // still driving the request so the caller can chain another one back-to-back.
  task automatic xfer(input int d, input logic [AW-1:0] a, input logic [DW-1:0] w,
                      input logic [NB-1:0] s, output logic [DW-1:0] rd);
    int lat   = (d != 0) ? LAT_B : LAT_A;
    int maxc  = (d != 0) ? (2**CW_B - 1) : (2**CW_A - 1);
    int depth = (d != 0) ? 2**MA_B : 2**MA_A;
    int idx   = (int'(a) / NB) % depth;
    int cyc   = 0;
    drive(d, 1'b1, a, w, s);
    while (!get_ready(d) && cyc < lat + 4) begin
      @(posedge clk); #1;
      cyc++;
    end
    ready_at = cyc_cnt;
    check("latency", cyc, lat);
    rd = get_rdata(d);
    if (s == '0) check("rdata", rd, model[d][idx]);
    check("cnt_in_resp", (s == '0) ? get_rdcnt(d) : get_wrcnt(d), (s == '0) ? rd_m[d] : wr_m[d]);
    if (s == '0) begin
      if (rd_m[d] < maxc) rd_m[d]++;
    end else begin
      if (wr_m[d] < maxc) wr_m[d]++;
      for (int b = 0; b < NB; b++)
        if (s[b]) model[d][idx][b*8 +: 8] = w[b*8 +: 8];
    end
    @(posedge clk); #1;
    check("ready_one_cycle", get_ready(d), 1'b0);
    check("rd_cnt", get_rdcnt(d), rd_m[d]);
    check("wr_cnt", get_wrcnt(d), wr_m[d]);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] r, old;
    logic [NB-1:0] st;
    logic [AW-1:0] a;
    int t0;
    ca = 1'b0; cb = 1'b0;
    idle(0, 0); idle(1, 0);
    rd_m[0] = 0; rd_m[1] = 0; wr_m[0] = 0; wr_m[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_a", ya, 0);  check("rst_ready_b", yb, 0);
    check("rst_rdata_a", ra, 0);  check("rst_rdata_b", rb, 0);
    check("rst_rdcnt_a", rca, 0); check("rst_wrcnt_b", wcb, 0);
    check("rst_pe_a", pa, 0);     check("rst_pe_b", pb, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: full write, read back, partial write, read back.
    xfer(0, 12'h040, 32'hDEADBEEF, 4'hF, r);
    idle(0, 1);
    xfer(0, 12'h040, '0, '0, r);
    check("plan_read", r, 32'hDEADBEEF);
    check("plan_rdcnt", rca, 1);
    idle(0, 1);
    xfer(0, 12'h040, 32'h11223344, 4'b0101, r);
    xfer(0, 12'h040, '0, '0, r);
    check("plan_partial", r, 32'hDE22BE44);
    check("plan_wrcnt", wca, 2);
    idle(0, 1);

    // Instance A: fill a 32-word window, then random mixed traffic inside it.
    for (int i = 0; i < 32; i++) xfer(0, AW'(i * 4), DW'($urandom), 4'hF, r);
    for (int i = 0; i < 60; i++) begin
      a  = AW'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      st = ($urandom_range(0, 1) != 0) ? NB'($urandom_range(1, 15)) : '0;
      xfer(0, a, DW'($urandom), st, r);
      idle(0, $urandom_range(0, 2));
    end

    // Instance B: fill all 16 words through aliased addresses, then burst and random traffic.
    for (int i = 0; i < 16; i++)
      xfer(1, AW'(($urandom_range(0, 63) * 64) + i * 4), DW'($urandom), 4'hF, r);
    idle(1, 1);
    for (int i = 0; i < 4; i++) xfer(1, AW'(12'h080 + i * 4), 32'hA5A50000 + DW'(i), 4'hF, r);
    idle(1, 2);
    t0 = cyc_cnt;
    for (int i = 0; i < 4; i++) begin
      xfer(1, AW'(12'h080 + i * 4), '0, '0, r);
      check("burst_data", r, 32'hA5A50000 + DW'(i));
      check("burst_cycle", ready_at - t0, 2 * i + 1);
    end
    xfer(1, 12'h080, '0, '0, r);
    check("sat_rdcnt", rcb, 3);
    check("sat_wrcnt", wcb, 3);
    for (int i = 0; i < 40; i++) begin
      st = ($urandom_range(0, 1) != 0) ? NB'($urandom_range(1, 15)) : '0;
      xfer(1, AW'($urandom), DW'($urandom), st, r);
      idle(1, $urandom_range(0, 2));
    end
    check("pe_clean_a", pa, 0);
    check("pe_clean_b", pb, 0);

    // Protocol: address changed during WAIT sets a sticky flag.
    drive(0, 1'b1, 12'h044, '0, '0);
    @(posedge clk); #1;
    aa = 12'h048;
    @(posedge clk); #1;
    check("pe_set", pa, 1);
    check("pe_ready", ya, 1);
    @(posedge clk); #1;
    if (rd_m[0] < 2**CW_A - 1) rd_m[0]++;
    idle(0, 3);
    check("pe_sticky", pa, 1);
    ca = 1'b1;
    @(posedge clk); #1;
    ca = 1'b0;
    check("pe_clr", pa, 0);
    // Dropped valid in WAIT while clearing: the set wins.
    drive(0, 1'b1, 12'h04C, '0, '0);
    @(posedge clk); #1;
    va = 1'b0; ca = 1'b1;
    @(posedge clk); #1;
    check("pe_set_wins", pa, 1);
    ca = 1'b0;
    @(posedge clk); #1;
    if (rd_m[0] < 2**CW_A - 1) rd_m[0]++;
    check("pe_rdcnt", rca, rd_m[0]);
    ca = 1'b1;
    @(posedge clk); #1;
    ca = 1'b0;
    check("pe_clr2", pa, 0);

    // Reset during the WAIT cycle of a write discards it.
    old = model[0][20];
    drive(0, 1'b1, 12'h050, ~old, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", ya, 0);
    check("mid_rst_rdata", ra, 0);
    check("mid_rst_rdcnt", rca, 0);
    check("mid_rst_wrcnt", wca, 0);
    check("mid_rst_rdcnt_b", rcb, 0);
    idle(0, 0);
    rd_m[0] = 0; rd_m[1] = 0; wr_m[0] = 0; wr_m[1] = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 12'h050, '0, '0, r);
    check("rst_keep_word", r, old);
    check("rst_rdcnt_after", rca, 1);
    idle(0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
